// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and stall controller for a five-stage in-order pipeline. It detects
// load-use hazards between ID and EXE, flushes wrong-path instructions on a
// taken branch, and freezes the pipeline while the MEM stage waits for memory.
// The pipeline-register controls are combinational on the current cycle so
// that the stall/flush takes effect on the very next clock edge.
//
// Parameters
//   REG_FILE_ADDR_LEN : register-address width
//   LOAD_STALL        : bubbles inserted per load-use hazard (1..7)
//
// Ports
//   clk, rst                : clock, asynchronous active-high reset
//   id_src1/id_src2         : source registers of the instruction in ID
//   id_use_src1/id_use_src2 : matching source is actually read
//   exe_dest                : destination of the instruction in ID/EXE
//   exe_mem_r_en            : instruction in EXE is a load
//   br_taken                : taken branch resolved in EXE this cycle
//   mem_req, mem_ready      : MEM stage accessing memory / memory done
//   pc_hold .. exemem_hold  : pipeline register controls
//   state                   : RUN=0, LDSTALL=1, MEMWAIT=2
//   stall_cnt               : saturating count of cycles with pc_hold=1
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_FILE_ADDR_LEN = 4,
  parameter int LOAD_STALL        = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REG_FILE_ADDR_LEN-1:0] id_src1,
  input  logic [REG_FILE_ADDR_LEN-1:0] id_src2,
  input  logic                         id_use_src1,
  input  logic                         id_use_src2,
  input  logic [REG_FILE_ADDR_LEN-1:0] exe_dest,
  input  logic                         exe_mem_r_en,
  input  logic                         br_taken,
  input  logic                         mem_req,
  input  logic                         mem_ready,
  output logic                         pc_hold,
  output logic                         ifid_hold,
  output logic                         ifid_flush,
  output logic                         idexe_hold,
  output logic                         idexe_bubble,
  output logic                         exemem_hold,
  output logic [1:0]                   state,
  output logic [15:0]                  stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  // Bubbles still owed after the first one, loaded when a hazard is detected.
  localparam logic [2:0] REMAIN_INIT = 3'(LOAD_STALL - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  state_t      ret_state_r;
  state_t      ret_state_nxt_s;
  logic [2:0]  remain_r;
  logic [2:0]  remain_nxt_s;
  logic [15:0] stall_cnt_r;

  logic hazard_s;
  logic memwait_s;
  logic pc_hold_s;
  logic ifid_hold_s;
  logic ifid_flush_s;
  logic idexe_hold_s;
  logic idexe_bubble_s;
  logic exemem_hold_s;

  // Load-use hazard and memory-wait detection.
  always_comb begin
    hazard_s  = exe_mem_r_en &&
                (exe_dest != {REG_FILE_ADDR_LEN{1'b0}}) &&
                ((id_use_src1 && (id_src1 == exe_dest)) ||
                 (id_use_src2 && (id_src2 == exe_dest)));
    memwait_s = mem_req && !mem_ready;
  end

  // Next-state and pipeline-control decode; priority memwait > branch > hazard.
  always_comb begin
    state_nxt_s     = state_r;
    ret_state_nxt_s = ret_state_r;
    remain_nxt_s    = remain_r;
    pc_hold_s       = 1'b0;
    ifid_hold_s     = 1'b0;
    ifid_flush_s    = 1'b0;
    idexe_hold_s    = 1'b0;
    idexe_bubble_s  = 1'b0;
    exemem_hold_s   = 1'b0;

    case (state_r)
      RUN: begin
        if (memwait_s) begin
          pc_hold_s       = 1'b1;
          ifid_hold_s     = 1'b1;
          idexe_hold_s    = 1'b1;
          exemem_hold_s   = 1'b1;
          state_nxt_s     = MEMWAIT;
          ret_state_nxt_s = RUN;
        end else if (br_taken) begin
          // The branch squashes the instruction in ID, so any hazard it has
          // is irrelevant.
          ifid_flush_s   = 1'b1;
          idexe_bubble_s = 1'b1;
          state_nxt_s    = RUN;
        end else if (hazard_s) begin
          pc_hold_s      = 1'b1;
          ifid_hold_s    = 1'b1;
          idexe_bubble_s = 1'b1;
          if (LOAD_STALL > 1) begin
            state_nxt_s  = LDSTALL;
            remain_nxt_s = REMAIN_INIT;
          end else begin
            state_nxt_s  = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end

      LDSTALL: begin
        if (memwait_s) begin
          // Freeze with remain untouched; the stall resumes after release.
          pc_hold_s       = 1'b1;
          ifid_hold_s     = 1'b1;
          idexe_hold_s    = 1'b1;
          exemem_hold_s   = 1'b1;
          state_nxt_s     = MEMWAIT;
          ret_state_nxt_s = LDSTALL;
        end else if (br_taken) begin
          ifid_flush_s   = 1'b1;
          idexe_bubble_s = 1'b1;
          state_nxt_s    = RUN;
          remain_nxt_s   = 3'd0;
        end else begin
          pc_hold_s      = 1'b1;
          ifid_hold_s    = 1'b1;
          idexe_bubble_s = 1'b1;
          // A zero remain cannot be reached legally; treat it as the last one.
          if (remain_r <= 3'd1) begin
            state_nxt_s  = RUN;
            remain_nxt_s = 3'd0;
          end else begin
            state_nxt_s  = LDSTALL;
            remain_nxt_s = remain_r - 3'd1;
          end
        end
      end

      MEMWAIT: begin
        // EXE is frozen here, so a branch is re-presented after release.
        if (!mem_ready) begin
          pc_hold_s     = 1'b1;
          ifid_hold_s   = 1'b1;
          idexe_hold_s  = 1'b1;
          exemem_hold_s = 1'b1;
          state_nxt_s   = MEMWAIT;
        end else begin
          state_nxt_s   = ret_state_r;
        end
      end

      default: begin
        state_nxt_s     = RUN;
        ret_state_nxt_s = RUN;
        remain_nxt_s    = 3'd0;
      end
    endcase
  end

  // Outputs are forced low during reset; flush always overrides an IF/ID hold.
  assign pc_hold      = !rst && pc_hold_s;
  assign ifid_flush   = !rst && ifid_flush_s;
  assign ifid_hold    = !rst && ifid_hold_s && !ifid_flush_s;
  assign idexe_hold   = !rst && idexe_hold_s;
  assign idexe_bubble = !rst && idexe_bubble_s;
  assign exemem_hold  = !rst && exemem_hold_s;
  assign state        = state_r;
  assign stall_cnt    = stall_cnt_r;

  // Controller state, return state, bubble counter and saturating stall count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      ret_state_r <= RUN;
      remain_r    <= 3'd0;
      stall_cnt_r <= 16'd0;
    end else begin
      state_r     <= state_nxt_s;
      ret_state_r <= ret_state_nxt_s;
      remain_r    <= remain_nxt_s;
      if (pc_hold && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Drives two controllers (LOAD_STALL=1 and LOAD_STALL=3) from shared inputs.
// A cycle-level reference model, written from the hazard/stall rules as
// "bubbles owed" and "memory frozen" bookkeeping, predicts outputs, state and
// stall count every cycle. Table vectors and hand sequences add fixed values.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       u1;
    logic       u2;
    logic [3:0] d;
    logic       ld;
    logic       br;
    logic       rq;
    logic       rd;
  } in_t;

  typedef struct {
    in_t        vin;
    logic [5:0] exp1;
  } vec_t;

  // Output bundle order: {pc, ifid_hold, ifid_flush, idexe_hold, bubble, exemem}
  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] STALL = 6'b110010;
  localparam logic [5:0] HOLD4 = 6'b110101;
  localparam logic [5:0] FLUSH = 6'b001010;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] id_src1, id_src2, exe_dest;
  logic id_use_src1, id_use_src2, exe_mem_r_en, br_taken, mem_req, mem_ready;

  logic pc_hold1, ifid_hold1, ifid_flush1, idexe_hold1, idexe_bubble1, exemem_hold1;
  logic pc_hold3, ifid_hold3, ifid_flush3, idexe_hold3, idexe_bubble3, exemem_hold3;
  logic [1:0]  state1, state3;
  logic [15:0] cnt1, cnt3;
  logic [5:0]  o1, o3;

  assign o1 = {pc_hold1, ifid_hold1, ifid_flush1, idexe_hold1, idexe_bubble1, exemem_hold1};
  assign o3 = {pc_hold3, ifid_hold3, ifid_flush3, idexe_hold3, idexe_bubble3, exemem_hold3};

  int checks = 0;
  int errors = 0;

  int m_left   [2];
  bit m_frozen [2];
  int m_cnt    [2];
  int m_ls     [2];

  vec_t tbl [9];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_FILE_ADDR_LEN(4), .LOAD_STALL(1)) d1 (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(pc_hold1), .ifid_hold(ifid_hold1), .ifid_flush(ifid_flush1),
    .idexe_hold(idexe_hold1), .idexe_bubble(idexe_bubble1), .exemem_hold(exemem_hold1),
    .state(state1), .stall_cnt(cnt1)
  );

  pipeline_hazard_ctrl #(.REG_FILE_ADDR_LEN(4), .LOAD_STALL(3)) d3 (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(pc_hold3), .ifid_hold(ifid_hold3), .ifid_flush(ifid_flush3),
    .idexe_hold(idexe_hold3), .idexe_bubble(idexe_bubble3), .exemem_hold(exemem_hold3),
    .state(state3), .stall_cnt(cnt3)
  );

  function automatic in_t mk(input logic [3:0] s1, input logic [3:0] s2,
                             input logic u1, input logic u2, input logic [3:0] d,
                             input logic ld, input logic br, input logic rq,
                             input logic rd);
    in_t v;
    v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2; v.d = d;
    v.ld = ld; v.br = br; v.rq = rq; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    id_src1      = v.s1;
    id_src2      = v.s2;
    id_use_src1  = v.u1;
    id_use_src2  = v.u2;
    exe_dest     = v.d;
    exe_mem_r_en = v.ld;
    br_taken     = v.br;
    mem_req      = v.rq;
    mem_ready    = v.rd;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k]   = 0;
      m_frozen[k] = 1'b0;
      m_cnt[k]    = 0;
    end
  endtask

  // Expected outputs/state/count for this cycle, then advance the model.
  task automatic model_step(input int k, input in_t v, output logic [5:0] eo,
                            output logic [1:0] es, output logic [15:0] ec);
    bit hz;
    bit mw;
    es = m_frozen[k] ? 2'd2 : ((m_left[k] > 0) ? 2'd1 : 2'd0);
    ec = 16'(m_cnt[k]);
    hz = v.ld && (v.d != 4'd0) && ((v.u1 && v.s1 == v.d) || (v.u2 && v.s2 == v.d));
    mw = v.rq && !v.rd;
    eo = NONE;
    if (m_frozen[k]) begin
      if (!v.rd) eo = HOLD4;
      else m_frozen[k] = 1'b0;
    end else if (mw) begin
      eo = HOLD4;
      m_frozen[k] = 1'b1;
    end else if (v.br) begin
      eo = FLUSH;
      m_left[k] = 0;
    end else if (m_left[k] > 0) begin
      eo = STALL;
      m_left[k]--;
    end else if (hz) begin
      eo = STALL;
      m_left[k] = m_ls[k] - 1;
    end
    if (eo[5]) m_cnt[k] = (m_cnt[k] >= 65535) ? 65535 : m_cnt[k] + 1;
  endtask

  // One cycle: drive after the falling edge, compare 1 time unit later.
  task automatic apply(input in_t v, input bit do_chk);
    logic [5:0]  eo;
    logic [1:0]  es;
    logic [15:0] ec;
    @(negedge clk);
    drive(v);
    #1;
    model_step(0, v, eo, es, ec);
    if (do_chk) begin
      chk("d1_outputs", 32'(o1), 32'(eo));
      chk("d1_state", 32'(state1), 32'(es));
      chk("d1_stall_cnt", 32'(cnt1), 32'(ec));
    end
    model_step(1, v, eo, es, ec);
    if (do_chk) begin
      chk("d3_outputs", 32'(o3), 32'(eo));
      chk("d3_state", 32'(state3), 32'(es));
      chk("d3_stall_cnt", 32'(cnt3), 32'(ec));
    end
  endtask

  // Reset with hazard and memwait inputs active: every output must stay low.
  task automatic do_reset();
    @(negedge clk);
    drive(mk(4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0));
    rst = 1'b1;
    #1;
    chk("rst_d1_outputs", 32'(o1), 32'(NONE));
    chk("rst_d3_outputs", 32'(o3), 32'(NONE));
    chk("rst_d1_state", 32'(state1), 32'd0);
    chk("rst_d3_cnt", 32'(cnt3), 32'd0);
    drive(mk(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t hz3;
    in_t idle;
    in_t mw;
    in_t rel;
    in_t r;
    logic [5:0] seq_o [9];
    logic [1:0] seq_s [9];

    m_ls[0] = 1;
    m_ls[1] = 3;
    model_reset();
    rst = 1'b1;
    drive(mk(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));

    hz3  = mk(4'd0, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    idle = mk(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    mw   = mk(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rel  = mk(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    tbl[0] = '{vin: hz3, exp1: STALL};
    tbl[1] = '{vin: mk(4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1), exp1: NONE};
    tbl[2] = '{vin: mk(4'd0, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1), exp1: NONE};
    tbl[3] = '{vin: mk(4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1), exp1: STALL};
    tbl[4] = '{vin: mk(4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1), exp1: NONE};
    tbl[5] = '{vin: mk(4'd0, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1), exp1: FLUSH};
    tbl[6] = '{vin: mk(4'd1, 4'd2, 1'b1, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0), exp1: FLUSH};
    tbl[7] = '{vin: mk(4'd7, 4'd7, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1), exp1: NONE};
    tbl[8] = '{vin: mk(4'd15, 4'd0, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1), exp1: STALL};

    // Reset state and single-cycle vectors on the LOAD_STALL=1 instance.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].vin, 1'b1);
      chk($sformatf("tbl%0d_d1", i), 32'(o1), 32'(tbl[i].exp1));
    end

    // Load-use with LOAD_STALL=1: one bubble, stall_cnt 1.
    do_reset();
    apply(hz3, 1'b1);
    apply(idle, 1'b1);
    chk("ls1_state", 32'(state1), 32'd0);
    chk("ls1_cnt", 32'(cnt1), 32'd1);

    // LOAD_STALL=3: states 0,1,1,0 and three stall cycles.
    do_reset();
    seq_s[0] = 2'd0; seq_s[1] = 2'd1; seq_s[2] = 2'd1; seq_s[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      apply((i < 3) ? hz3 : idle, 1'b1);
      chk($sformatf("ls3_state%0d", i), 32'(state3), 32'(seq_s[i]));
      chk($sformatf("ls3_pc_hold%0d", i), 32'(pc_hold3), (i < 3) ? 32'd1 : 32'd0);
    end
    chk("ls3_cnt", 32'(cnt3), 32'd3);

    // Branch together with a hazard: flush only, no stall counted.
    do_reset();
    apply(mk(4'd0, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1), 1'b1);
    chk("br_haz_d3_out", 32'(o3), 32'(FLUSH));
    apply(idle, 1'b1);
    chk("br_haz_d3_state", 32'(state3), 32'd0);
    chk("br_haz_d3_cnt", 32'(cnt3), 32'd0);

    // Memory wait inside LDSTALL (remain=2): 4 frozen, release, 2 more stalls.
    do_reset();
    seq_o[0] = STALL; seq_o[1] = HOLD4; seq_o[2] = HOLD4; seq_o[3] = HOLD4;
    seq_o[4] = HOLD4; seq_o[5] = NONE;  seq_o[6] = STALL; seq_o[7] = STALL;
    seq_o[8] = NONE;
    seq_s[0] = 2'd0; seq_s[1] = 2'd1; seq_s[2] = 2'd2; seq_s[3] = 2'd2;
    seq_s[4] = 2'd2; seq_s[5] = 2'd2; seq_s[6] = 2'd1; seq_s[7] = 2'd1;
    seq_s[8] = 2'd0;
    for (int i = 0; i < 9; i++) begin
      apply((i == 0) ? hz3 : (i < 5) ? mw : (i == 5) ? rel : idle, 1'b1);
      chk($sformatf("mw_ld_out%0d", i), 32'(o3), 32'(seq_o[i]));
      chk($sformatf("mw_ld_state%0d", i), 32'(state3), 32'(seq_s[i]));
    end
    chk("mw_ld_cnt", 32'(cnt3), 32'd7);

    // Asynchronous reset pulse between edges while in MEMWAIT.
    do_reset();
    apply(mw, 1'b1);
    apply(mw, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_d1_out", 32'(o1), 32'(NONE));
    chk("arst_d3_out", 32'(o3), 32'(NONE));
    chk("arst_d1_state", 32'(state1), 32'd0);
    chk("arst_d1_cnt", 32'(cnt1), 32'd0);
    drive(idle);
    #1 rst = 1'b0;
    model_reset();
    apply(hz3, 1'b1);
    chk("arst_after_d1", 32'(o1), 32'(STALL));

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r.s1 = 4'($urandom_range(0, 3));
      r.s2 = 4'($urandom_range(0, 3));
      r.u1 = 1'($urandom_range(0, 1));
      r.u2 = 1'($urandom_range(0, 1));
      r.d  = 4'($urandom_range(0, 3));
      r.ld = 1'($urandom_range(0, 1));
      r.br = ($urandom_range(0, 7) == 0);
      r.rq = ($urandom_range(0, 3) == 0);
      r.rd = ($urandom_range(0, 2) != 0);
      apply(r, 1'b1);
    end

    // Saturation: hold until stall_cnt reaches 0xFFFE, then three more holds.
    do_reset();
    for (int i = 0; i < 65534; i++) apply(mw, 1'b0);
    apply(mw, 1'b1);
    chk("sat_pre_d1", 32'(cnt1), 32'h0000_FFFE);
    apply(mw, 1'b1);
    apply(mw, 1'b1);
    apply(rel, 1'b1);
    chk("sat_d1", 32'(cnt1), 32'h0000_FFFF);
    chk("sat_d3", 32'(cnt3), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have the parameter REG_FILE_ADDR_LEN, default 4, meaning register-address width.
REQ-002 The block SHALL have the parameter LOAD_STALL, default 1, range 1-7, meaning bubbles inserted per load-use hazard.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have the ports id_src1 and id_src2, input, REG_FILE_ADDR_LEN bits each: source registers of the instruction in ID.
REQ-006 The block SHALL have the ports id_use_src1 and id_use_src2, input, 1 bit each: the matching source is actually read.
REQ-007 The block SHALL have the port exe_dest, input, REG_FILE_ADDR_LEN bits: destination of the instruction held in the ID/EXE register.
REQ-008 The block SHALL have the port exe_mem_r_en, input, 1 bit: the instruction in EXE is a load.
REQ-009 The block SHALL have the port br_taken, input, 1 bit: a taken branch resolved in EXE this cycle.
REQ-010 The block SHALL have the ports mem_req and mem_ready, input, 1 bit each: the MEM stage is accessing memory; memory completes this cycle.
REQ-011 The block SHALL have the ports pc_hold, ifid_hold, ifid_flush, idexe_hold, idexe_bubble and exemem_hold, output, 1 bit each: pipeline register controls.
REQ-012 The block SHALL have the port state, output, 2 bits: RUN=0, LDSTALL=1, MEMWAIT=2.
REQ-013 The block SHALL have the port stall_cnt, output, 16 bits: count of cycles with pc_hold=1.

Function
REQ-014 In RUN, hazard SHALL equal exe_mem_r_en AND exe_dest!=0 AND ((id_use_src1 AND id_src1==exe_dest) OR (id_use_src2 AND id_src2==exe_dest)).
REQ-015 In RUN, the priority SHALL be memwait (mem_req AND NOT mem_ready), then br_taken, then hazard; all outputs SHALL be combinational on the current cycle.
REQ-016 On memwait, pc_hold, ifid_hold, idexe_hold and exemem_hold SHALL be 1, and the next state SHALL be MEMWAIT with ret_state=current state.
REQ-017 On br_taken without memwait, ifid_flush and idexe_bubble SHALL be 1 for that cycle, pc SHALL NOT be held, and the state SHALL remain RUN; a simultaneous hazard SHALL be ignored.
REQ-018 On hazard alone, pc_hold, ifid_hold and idexe_bubble SHALL be 1; if LOAD_STALL>1, the next state SHALL be LDSTALL with remain=LOAD_STALL-1, otherwise RUN.
REQ-019 In LDSTALL, pc_hold, ifid_hold and idexe_bubble SHALL be 1 each cycle and remain SHALL decrement; at remain==1 the next state SHALL be RUN.
REQ-020 In LDSTALL, memwait SHALL take priority (MEMWAIT, remain frozen); br_taken SHALL flush as in REQ-017 and SHALL abort to RUN with remain cleared.
REQ-021 In MEMWAIT, the four hold outputs SHALL stay 1 while mem_ready=0; when mem_ready=1, holds SHALL be 0 that cycle and the next state SHALL be ret_state with remain unchanged.
REQ-022 br_taken SHALL be ignored in MEMWAIT, because EXE is frozen and the branch is re-presented after release.
REQ-023 ifid_flush and ifid_hold SHALL never both be 1; if a rule sets both, flush wins.
REQ-024 stall_cnt SHALL increment every cycle pc_hold=1 and SHALL saturate at 0xFFFF.

Reset
REQ-025 While rst=1, all outputs SHALL be 0 (state=RUN), regardless of inputs.
REQ-026 rst SHALL asynchronously clear state, ret_state, remain and stall_cnt, including mid-LDSTALL or mid-MEMWAIT.
REQ-027 The first rising edge after rst falls SHALL evaluate inputs normally from RUN.

Verification
REQ-028 Load-use: exe_mem_r_en=1, exe_dest=3, id_src2=3, id_use_src2=1, LOAD_STALL=1 -> one cycle of pc_hold=ifid_hold=idexe_bubble=1, then RUN, stall_cnt=1.
REQ-029 LOAD_STALL=3 with the same hazard -> 3 consecutive stall cycles, state sequence 0,1,1,0, stall_cnt=3.
REQ-030 br_taken=1 together with a hazard -> ifid_flush=idexe_bubble=1, pc_hold=0, state stays 0, stall_cnt unchanged.
REQ-031 A hazard where exe_dest=0 or id_use_src*=0 -> no outputs asserted.
REQ-032 mem_req=1 and mem_ready=0 for 4 cycles during LDSTALL (remain=2) -> 4 frozen cycles, then mem_ready -> return to LDSTALL with remain=2, and stall completion follows.
REQ-033 rst pulse mid-MEMWAIT between clock edges -> outputs 0 immediately, state=0, stall_cnt=0; stall_cnt preloaded to 0xFFFE then 3 stall cycles -> reads 0xFFFF.
